// File: rtl/clock_monitor_pkg.sv
// clk_mon_pkg: FSM encoding and default divider timing shared by the clock monitor.
// Rev 1.0
`default_nettype none

package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } state_t;

  // Must match the divider's terminal count so both ends agree on the half-period.
  localparam int DEF_EXP_HALF = 250001;
  localparam int DEF_TOL      = 16;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer plus history flop; flags either edge of din.
// Rev 1.0
`default_nettype none

module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_det
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 ^ s3;

endmodule

`default_nettype wire

// File: rtl/clock_monitor.sv
// clock_monitor: measures each half-period of a slow clock in clk cycles, reports range, lock and loss.
// Rev 1.0
`default_nettype none

module clock_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = 20,
  parameter int EXP_HALF = DEF_EXP_HALF,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_N   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             locked,
  output logic             lost,
  output logic [15:0]      edge_count
);

  // Requires TOL < EXP_HALF and EXP_HALF+TOL < 2**CNT_W.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W:0]   LO_LIM   = (CNT_W+1)'(EXP_HALF - TOL);
  localparam logic [CNT_W:0]   HI_LIM   = (CNT_W+1)'(EXP_HALF + TOL);
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_N);

  state_t           state;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lock_cnt;
  logic [CNT_W:0]   meas;
  logic             meas_ok;
  logic [3:0]       lock_next;

  sync_edge_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (clk_in),
    .edge_det (edge_det)
  );

  always_comb begin
    meas      = {1'b0, cnt} + (CNT_W+1)'(1);
    meas_ok   = (meas >= LO_LIM) && (meas <= HI_LIM);
    lock_next = 4'd0;
    if (meas_ok) begin
      lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lock_cnt     <= 4'd0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
      edge_count   <= 16'd0;
    end else begin
      period_valid <= 1'b0;

      if (edge_det) begin
        cnt        <= '0;
        edge_count <= edge_count + 16'd1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (edge_det) state <= TRACK;
        end
        TRACK: begin
          // An edge on the saturation cycle is still a measurement, never a loss.
          if (edge_det) begin
            period       <= meas[CNT_W-1:0];
            period_valid <= 1'b1;
            in_range     <= meas_ok;
            lock_cnt     <= lock_next;
            locked       <= (lock_next == LOCK_MAX);
          end else if (cnt == CNT_MAX) begin
            state    <= LOST;
            lost     <= 1'b1;
            locked   <= 1'b0;
            lock_cnt <= 4'd0;
          end
        end
        LOST: begin
          if (edge_det) begin
            state <= TRACK;
            lost  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed stimulus with a reference model feeding a scoreboard of expected measurements.
// Rev 1.0
`default_nettype none

module tb_clock_monitor;

  localparam int CNT_W    = 8;
  localparam int EXP_HALF = 10;
  localparam int TOL      = 2;
  localparam int LOCK_N   = 2;

  logic             clk;
  logic             reset;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             in_range;
  logic             locked;
  logic             lost;
  logic [15:0]      edge_count;

  clock_monitor #(
    .CNT_W    (CNT_W),
    .EXP_HALF (EXP_HALF),
    .TOL      (TOL),
    .LOCK_N   (LOCK_N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_in       (clk_in),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .locked       (locked),
    .lost         (lost),
    .edge_count   (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p;
    int r;
    int l;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  // Reference model: 0 idle, 1 track, 2 lost
  int          mstate = 0;
  int          since  = 0;
  int          mlock  = 0;
  logic [15:0] mec    = 16'd0;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
    since += n;
  endtask

  task automatic toggle();
    exp_t e;
    if (mstate == 1 && since > EXP_HALF + TOL + 1) begin
      mstate = 2;
      mlock  = 0;
    end
    if (mstate == 1) begin
      e.p   = since;
      e.r   = (since >= EXP_HALF - TOL && since <= EXP_HALF + TOL) ? 1 : 0;
      mlock = (e.r == 1) ? ((mlock < LOCK_N) ? mlock + 1 : LOCK_N) : 0;
      e.l   = (mlock == LOCK_N) ? 1 : 0;
      q.push_back(e);
    end
    mstate = 1;
    mec    = mec + 16'd1;
    since  = 0;
    clk_in = ~clk_in;
  endtask

  task automatic check_ec();
    wait_n(3);
    chk("edge_count", int'(edge_count), int'(mec));
  endtask

  always begin
    @(posedge clk);
    #1;
    if (period_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_pv", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("period", int'(period), mon_e.p);
        chk("in_range", int'(in_range), mon_e.r);
        chk("locked", int'(locked), mon_e.l);
      end
    end
  end

  initial begin
    int n;
    reset  = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_pv", int'(period_valid), 0);
    chk("rst_in_range", int'(in_range), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_lost", int'(lost), 0);
    chk("rst_edge_count", int'(edge_count), 0);
    reset = 1'b0;
    since = 0;

    // Nominal 10-cycle toggling: first edge unmeasured, lock at second pulse
    wait_n(5);
    toggle();
    for (int i = 0; i < 4; i++) begin
      wait_n(10);
      toggle();
    end
    check_ec();

    wait_n(9);  toggle();
    wait_n(13); toggle();
    wait_n(8);  toggle();
    wait_n(7);  toggle();
    wait_n(10); toggle();
    wait_n(10); toggle();
    check_ec();
    chk("locked_before_loss", int'(locked), 1);

    // Loss of signal: lost rises 13 cycles after the last detected edge
    wait_n(12);
    chk("lost_early", int'(lost), 0);
    wait_n(1);
    chk("lost_set", int'(lost), 1);
    chk("lost_unlocked", int'(locked), 0);
    wait_n(4);
    toggle();
    wait_n(3);
    chk("lost_cleared", int'(lost), 0);
    wait_n(7);
    toggle();

    // Edge on the saturation cycle: measurement of 13, no loss
    wait_n(13);
    toggle();
    wait_n(3);
    chk("sat_no_lost", int'(lost), 0);
    wait_n(7);  toggle();
    wait_n(10); toggle();
    if (clk_in) begin
      wait_n(10);
      toggle();
    end
    wait_n(4);
    chk("locked_before_reset", int'(locked), 1);

    // Reset mid-period while locked
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_pv", int'(period_valid), 0);
    chk("mid_rst_in_range", int'(in_range), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_lost", int'(lost), 0);
    chk("mid_rst_edge_count", int'(edge_count), 0);
    chk("mid_rst_state", int'(dut.state), 0);
    q.delete();
    mstate = 0;
    mlock  = 0;
    mec    = 16'd0;
    since  = 0;
    wait_n(6);
    toggle();
    wait_n(10);
    toggle();
    check_ec();

    // Wrap edge_count with a toggle on every clk
    n = 65536 - int'(mec);
    for (int i = 0; i < n; i++) begin
      wait_n(1);
      toggle();
    end
    wait_n(3);
    chk("edge_count_wrap", int'(edge_count), 0);
    for (int i = 0; i < 3; i++) begin
      wait_n(10);
      toggle();
    end
    check_ec();
    wait_n(5);
    chk("sb_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
